// File: rtl/control_step_sequencer.sv
// Control-step FSM for the 32-bit CPU: drives one-hot bus-source selects plus register, memory and ALU strobes.
// Fetch T0-T3, execute T4-T6; memory waits in T2 on mem_rdy with an optional timeout into HALT.
module control_step_sequencer #(
   parameter int MEM_WAIT_MAX = 0
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        run,
   input  logic [31:0] ir,
   input  logic        mem_rdy,
   output logic [15:0] reg_out,
   output logic [9:0]  bus_src,
   output logic        inport_out,
   output logic [15:0] reg_in,
   output logic        pc_in,
   output logic        ir_in,
   output logic        mar_in,
   output logic        mdr_in,
   output logic        y_in,
   output logic        z_in,
   output logic        inc_pc,
   output logic        mem_read,
   output logic [4:0]  alu_op,
   output logic        halted,
   output logic        mem_err
);

   typedef enum logic [3:0] {
      S_IDLE, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_HALT
   } state_t;

   localparam int          CNT_W     = 16;
   localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(MEM_WAIT_MAX - 1);
   localparam bit          TIMEOUT_EN = (MEM_WAIT_MAX != 0);

   state_t           state, state_nxt;
   logic [CNT_W-1:0] wait_cnt, wait_cnt_nxt;
   logic             err_q, err_nxt;

   logic [4:0] op;
   logic [3:0] ra, rb, rc;
   logic       is_rtype, is_imm, is_mfhi, is_mflo, is_in, is_halt;
   logic       unused_ir_bits;

   assign op = ir[31:27];
   assign ra = ir[26:23];
   assign rb = ir[22:19];
   assign rc = ir[18:15];
   assign unused_ir_bits = ^ir[14:0];

   assign is_rtype = (op >= 5'b00011) && (op <= 5'b01011);
   assign is_imm   = (op >= 5'b01100) && (op <= 5'b01110);
   assign is_mfhi  = (op == 5'b11000);
   assign is_mflo  = (op == 5'b11001);
   assign is_in    = (op == 5'b10110);
   assign is_halt  = (op == 5'b11011);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state    <= S_IDLE;
         wait_cnt <= '0;
         err_q    <= 1'b0;
      end else begin
         state    <= state_nxt;
         wait_cnt <= wait_cnt_nxt;
         err_q    <= err_nxt;
      end
   end

   // Instruction completion: the same edge re-enters fetch if run is still high.
   function automatic state_t done_state(input logic run_now);
      return run_now ? S_T0 : S_IDLE;
   endfunction

   always_comb begin
      state_nxt    = state;
      wait_cnt_nxt = '0;
      err_nxt      = err_q;
      reg_out      = '0;
      bus_src      = '0;
      inport_out   = 1'b0;
      reg_in       = '0;
      pc_in        = 1'b0;
      ir_in        = 1'b0;
      mar_in       = 1'b0;
      mdr_in       = 1'b0;
      y_in         = 1'b0;
      z_in         = 1'b0;
      inc_pc       = 1'b0;
      mem_read     = 1'b0;
      alu_op       = '0;
      halted       = 1'b0;

      case (state)
         S_IDLE: begin
            if (run) state_nxt = S_T0;
         end
         S_T0: begin
            bus_src[4] = 1'b1;
            mar_in     = 1'b1;
            inc_pc     = 1'b1;
            z_in       = 1'b1;
            state_nxt  = S_T1;
         end
         S_T1: begin
            bus_src[3] = 1'b1;
            pc_in      = 1'b1;
            mem_read   = 1'b1;
            state_nxt  = S_T2;
         end
         S_T2: begin
            mem_read = 1'b1;
            if (mem_rdy) begin
               mdr_in    = 1'b1;
               state_nxt = S_T3;
            end else if (TIMEOUT_EN && (wait_cnt == WAIT_LAST)) begin
               err_nxt   = 1'b1;
               state_nxt = S_HALT;
            end else begin
               wait_cnt_nxt = wait_cnt + 1'b1;
            end
         end
         S_T3: begin
            bus_src[5] = 1'b1;
            ir_in      = 1'b1;
            state_nxt  = S_T4;
         end
         S_T4: begin
            if (is_rtype || is_imm) begin
               reg_out[rb] = 1'b1;
               y_in        = 1'b1;
               state_nxt   = S_T5;
            end else if (is_mfhi) begin
               bus_src[0] = 1'b1;
               reg_in[ra] = 1'b1;
               state_nxt  = done_state(run);
            end else if (is_mflo) begin
               bus_src[1] = 1'b1;
               reg_in[ra] = 1'b1;
               state_nxt  = done_state(run);
            end else if (is_in) begin
               inport_out = 1'b1;
               reg_in[ra] = 1'b1;
               state_nxt  = done_state(run);
            end else if (is_halt) begin
               state_nxt = S_HALT;
            end else begin
               state_nxt = done_state(run);
            end
         end
         S_T5: begin
            alu_op = op;
            z_in   = 1'b1;
            if (is_rtype)    reg_out[rc] = 1'b1;
            else if (is_imm) bus_src[9]  = 1'b1;
            state_nxt = S_T6;
         end
         S_T6: begin
            bus_src[3] = 1'b1;
            reg_in[ra] = 1'b1;
            state_nxt  = done_state(run);
         end
         S_HALT: begin
            halted = 1'b1;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   assign mem_err = err_q;

endmodule

// File: tb/tb_control_step_sequencer.sv
// Bench for control_step_sequencer: a no-timeout instance and a MEM_WAIT_MAX=4 instance share stimulus.
module tb_control_step_sequencer;

   localparam int IDLE = -1;
   localparam int HALT = 7;
   localparam int C_OTHER = 0, C_RT = 1, C_IMM = 2, C_MFHI = 3, C_MFLO = 4, C_IN = 5, C_HALT = 6;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        run;
   logic [31:0] ir;
   logic        mem_rdy;

   logic [15:0] reg_out0, reg_in0, reg_out4, reg_in4;
   logic [9:0]  bus_src0, bus_src4;
   logic        inport0, pc_in0, ir_in0, mar_in0, mdr_in0, y_in0, z_in0, inc_pc0, mem_read0, halted0, mem_err0;
   logic        inport4, pc_in4, ir_in4, mar_in4, mdr_in4, y_in4, z_in4, inc_pc4, mem_read4, halted4, mem_err4;
   logic [4:0]  alu_op0, alu_op4;
   logic [57:0] got0, got4;

   int checks = 0;
   int failures = 0;

   int m_ph[2] = '{IDLE, IDLE};
   int m_wc[2] = '{0, 0};
   bit m_err[2] = '{1'b0, 1'b0};
   int wmax[2] = '{0, 4};

   control_step_sequencer #(.MEM_WAIT_MAX(0)) dut0 (
      .clk(clk), .reset_n(reset_n), .run(run), .ir(ir), .mem_rdy(mem_rdy),
      .reg_out(reg_out0), .bus_src(bus_src0), .inport_out(inport0), .reg_in(reg_in0),
      .pc_in(pc_in0), .ir_in(ir_in0), .mar_in(mar_in0), .mdr_in(mdr_in0), .y_in(y_in0), .z_in(z_in0),
      .inc_pc(inc_pc0), .mem_read(mem_read0), .alu_op(alu_op0), .halted(halted0), .mem_err(mem_err0)
   );

   control_step_sequencer #(.MEM_WAIT_MAX(4)) dut4 (
      .clk(clk), .reset_n(reset_n), .run(run), .ir(ir), .mem_rdy(mem_rdy),
      .reg_out(reg_out4), .bus_src(bus_src4), .inport_out(inport4), .reg_in(reg_in4),
      .pc_in(pc_in4), .ir_in(ir_in4), .mar_in(mar_in4), .mdr_in(mdr_in4), .y_in(y_in4), .z_in(z_in4),
      .inc_pc(inc_pc4), .mem_read(mem_read4), .alu_op(alu_op4), .halted(halted4), .mem_err(mem_err4)
   );

   assign got0 = {reg_out0, bus_src0, inport0, reg_in0, pc_in0, ir_in0, mar_in0, mdr_in0,
                  y_in0, z_in0, inc_pc0, mem_read0, alu_op0, halted0, mem_err0};
   assign got4 = {reg_out4, bus_src4, inport4, reg_in4, pc_in4, ir_in4, mar_in4, mdr_in4,
                  y_in4, z_in4, inc_pc4, mem_read4, alu_op4, halted4, mem_err4};

   always #5 clk = ~clk;

   function automatic int category(input logic [4:0] op);
      if (op >= 5'd3 && op <= 5'd11) return C_RT;
      if (op >= 5'd12 && op <= 5'd14) return C_IMM;
      case (op)
         5'd24: return C_MFHI;
         5'd25: return C_MFLO;
         5'd22: return C_IN;
         5'd27: return C_HALT;
         default: return C_OTHER;
      endcase
   endfunction

   function automatic logic [57:0] expect_out(input int ph, input logic [31:0] irv, input logic rdy, input logic err);
      logic [15:0] ro, ri;
      logic [9:0]  bs;
      logic        inp, pc, irl, mar, mdr, y, z, inc, mr, h;
      logic [4:0]  alu;
      int          c;
      ro = '0; ri = '0; bs = '0; alu = '0;
      inp = 0; pc = 0; irl = 0; mar = 0; mdr = 0; y = 0; z = 0; inc = 0; mr = 0; h = 0;
      c = category(irv[31:27]);
      case (ph)
         0: begin bs[4] = 1; mar = 1; inc = 1; z = 1; end
         1: begin bs[3] = 1; pc = 1; mr = 1; end
         2: begin mr = 1; mdr = rdy; end
         3: begin bs[5] = 1; irl = 1; end
         4: begin
            if (c == C_RT || c == C_IMM) begin ro[irv[22:19]] = 1; y = 1; end
            else if (c == C_MFHI) begin bs[0] = 1; ri[irv[26:23]] = 1; end
            else if (c == C_MFLO) begin bs[1] = 1; ri[irv[26:23]] = 1; end
            else if (c == C_IN)   begin inp = 1;   ri[irv[26:23]] = 1; end
         end
         5: begin
            alu = irv[31:27]; z = 1;
            if (c == C_RT) ro[irv[18:15]] = 1;
            else if (c == C_IMM) bs[9] = 1;
         end
         6: begin bs[3] = 1; ri[irv[26:23]] = 1; end
         HALT: h = 1;
         default: ;
      endcase
      return {ro, bs, inp, ri, pc, irl, mar, mdr, y, z, inc, mr, alu, h, err};
   endfunction

   // Reference sequencing: step number per instance, wait cycles spent in the memory step.
   always @(posedge clk or negedge reset_n) begin
      for (int k = 0; k < 2; k++) begin
         if (!reset_n) begin
            m_ph[k] = IDLE; m_wc[k] = 0; m_err[k] = 1'b0;
         end else begin
            int nx;
            int c;
            c = category(ir[31:27]);
            nx = m_ph[k];
            case (m_ph[k])
               IDLE: nx = run ? 0 : IDLE;
               0, 1, 3, 5: nx = m_ph[k] + 1;
               2: begin
                  if (mem_rdy) begin nx = 3; m_wc[k] = 0; end
                  else if (wmax[k] != 0 && m_wc[k] + 1 >= wmax[k]) begin
                     nx = HALT; m_err[k] = 1'b1; m_wc[k] = 0;
                  end else m_wc[k] = m_wc[k] + 1;
               end
               4: begin
                  if (c == C_RT || c == C_IMM) nx = 5;
                  else if (c == C_HALT) nx = HALT;
                  else nx = run ? 0 : IDLE;
               end
               6: nx = run ? 0 : IDLE;
               default: nx = HALT;
            endcase
            m_ph[k] = nx;
         end
      end
   end

   always @(negedge clk) begin
      logic [57:0] e, g;
      logic [15:0] ro;
      logic [9:0]  bs;
      logic        inp;
      logic [15:0] ri;
      for (int k = 0; k < 2; k++) begin
         g = (k == 0) ? got0 : got4;
         e = expect_out(m_ph[k], ir, mem_rdy, m_err[k]);
         checks++;
         if (g !== e) begin
            failures++;
            $display("FAIL model_cmp dut%0d t=%0t step=%0d got=%h exp=%h", k*4, $time, m_ph[k], g, e);
         end
         ro = g[57:42]; bs = g[41:32]; inp = g[31]; ri = g[30:15];
         checks++;
         if ($countones({ro, bs, inp}) > 1 || $countones(ri) > 1) begin
            failures++;
            $display("FAIL onehot dut%0d t=%0t drive=%h load=%h", k*4, $time, {ro, bs, inp}, ri);
         end
      end
   end

   task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", nm, got, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #2;
   endtask

   initial begin
      reset_n = 1'b0; run = 1'b0; ir = '0; mem_rdy = 1'b0;
      repeat (2) tick;
      chk("reset_state", 64'(got0), 64'd0);
      reset_n = 1'b1;

      // add R1,R2,R3 with memory ready at once
      ir = 32'h18918000; mem_rdy = 1'b1; run = 1'b1;
      tick;
      chk("t0_mar_in", 64'(mar_in0), 64'd1);
      chk("t0_bus_src", 64'(bus_src0), 64'h010);
      tick; tick;
      chk("t2_mdr_in", 64'(mdr_in0), 64'd1);
      tick; tick;
      chk("add_t4_reg_out", 64'(reg_out0), 64'h0004);
      chk("add_t4_y_in", 64'(y_in0), 64'd1);
      tick;
      chk("add_t5_reg_out", 64'(reg_out0), 64'h0008);
      chk("add_t5_z_in", 64'(z_in0), 64'd1);
      chk("add_t5_alu_op", 64'(alu_op0), 64'h03);
      tick;
      chk("add_t6_bus_src", 64'(bus_src0), 64'h008);
      chk("add_t6_reg_in", 64'(reg_in0), 64'h0002);
      tick;
      chk("refetch_t0", 64'(mar_in0), 64'd1);
      run = 1'b0;
      repeat (7) tick;
      chk("idle_after_run0", 64'(got0), 64'd0);

      // mflo R0 with three wait cycles
      ir = 32'hC8000000; mem_rdy = 1'b0; run = 1'b1;
      tick; tick;
      for (int i = 0; i < 3; i++) begin
         tick;
         chk("wait_mem_read", 64'(mem_read0), 64'd1);
         chk("wait_mdr_in", 64'(mdr_in0), 64'd0);
      end
      mem_rdy = 1'b1;
      #1;
      chk("rdy_mdr_in", 64'(mdr_in0), 64'd1);
      tick;
      chk("t3_mdr_in_clear", 64'(mdr_in0), 64'd0);
      chk("t3_ir_in", 64'(ir_in0), 64'd1);
      tick;
      chk("mflo_bus_src", 64'(bus_src0), 64'h002);
      chk("mflo_reg_in", 64'(reg_in0), 64'h0001);
      run = 1'b0;
      tick;
      chk("mflo_idle", 64'(got0), 64'd0);

      // addi R5,R6,-1 then halt
      ir = 32'h62B7FFFF; run = 1'b1; mem_rdy = 1'b1;
      repeat (5) tick;
      chk("addi_t4_reg_out", 64'(reg_out0), 64'h0040);
      tick;
      chk("addi_t5_bus_src", 64'(bus_src0), 64'h200);
      chk("addi_t5_alu_op", 64'(alu_op0), 64'h0C);
      tick;
      chk("addi_t6_reg_in", 64'(reg_in0), 64'h0020);
      ir = 32'hD8000000;
      repeat (5) tick;
      chk("halt_t4_quiet", 64'({reg_out0, reg_in0, halted0}), 64'd0);
      tick;
      chk("halt_halted", 64'(halted0), 64'd1);
      run = 1'b0; repeat (3) tick; run = 1'b1; repeat (2) tick;
      chk("halt_sticky", 64'({halted0, mar_in0}), 64'b10);
      reset_n = 1'b0; tick; reset_n = 1'b1;

      // memory timeout on the MEM_WAIT_MAX=4 instance
      run = 1'b1; mem_rdy = 1'b0; ir = '0;
      tick; tick;
      repeat (4) tick;
      chk("to_before", 64'({halted4, mem_read4}), 64'b01);
      tick;
      chk("to_halted", 64'({halted4, mem_err4}), 64'b11);
      chk("nowait_still_t2", 64'({halted0, mem_read0, mem_err0}), 64'b010);
      run = 1'b0; repeat (3) tick; run = 1'b1; repeat (2) tick;
      chk("to_sticky", 64'({halted4, mem_err4, mem_read0}), 64'b111);

      // asynchronous reset in the middle of a memory wait
      #1 reset_n = 1'b0;
      #1;
      chk("areset_dut0_zero", 64'(got0), 64'd0);
      chk("areset_dut4_zero", 64'(got4), 64'd0);
      tick;
      reset_n = 1'b1;
      tick;
      chk("post_reset_t0", 64'({mar_in0, mar_in4, mem_err4}), 64'b110);

      for (int i = 0; i < 2000; i++) begin
         if (i % 40 == 39) begin
            reset_n = 1'b0; #1; reset_n = 1'b1;
         end
         ir = $urandom;
         mem_rdy = ($urandom_range(0, 3) != 0);
         run = ($urandom_range(0, 7) != 0);
         tick;
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
